// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with flush/stall and optional bubble counter (ID_EX_BUBBLE_CNT_EN)
module id_ex_reg #(
    parameter int XLEN   = 32,
    parameter int ALUC_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              FlushE,
    input  logic              StallE,
    input  logic              ValidD,
    input  logic              RegWriteD,
    input  logic              MemWriteD,
    input  logic              JumpD,
    input  logic              BranchD,
    input  logic              ALUSrcD,
    input  logic [1:0]        ResultSrcD,
    input  logic [ALUC_W-1:0] ALUControlD,
    input  logic [XLEN-1:0]   RD1D,
    input  logic [XLEN-1:0]   RD2D,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic [XLEN-1:0]   ExtImmD,
    input  logic [4:0]        Rs1D,
    input  logic [4:0]        Rs2D,
    input  logic [4:0]        RdD,
    output logic              ValidE,
    output logic              RegWriteE,
    output logic              MemWriteE,
    output logic              JumpE,
    output logic              BranchE,
    output logic              ALUSrcE,
    output logic [1:0]        ResultSrcE,
    output logic [ALUC_W-1:0] ALUControlE,
    output logic [XLEN-1:0]   RD1E,
    output logic [XLEN-1:0]   RD2E,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic [XLEN-1:0]   ExtImmE,
    output logic [4:0]        Rs1E,
    output logic [4:0]        Rs2E,
    output logic [4:0]        RdE,
    output logic [15:0]       BubbleCntE
);

    // Flush outranks stall; an invalid Decode slot still carries its data
    // fields but must not commit any architectural side effect.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n || FlushE) begin
            ValidE      <= 1'b0;
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            ResultSrcE  <= '0;
            ALUControlE <= '0;
            RD1E        <= '0;
            RD2E        <= '0;
            PCE         <= '0;
            PCPlus4E    <= '0;
            ExtImmE     <= '0;
            Rs1E        <= '0;
            Rs2E        <= '0;
            RdE         <= '0;
        end else if (!StallE) begin
            ValidE      <= ValidD;
            RegWriteE   <= RegWriteD & ValidD;
            MemWriteE   <= MemWriteD & ValidD;
            JumpE       <= JumpD & ValidD;
            BranchE     <= BranchD & ValidD;
            ALUSrcE     <= ALUSrcD;
            ResultSrcE  <= ResultSrcD;
            ALUControlE <= ALUControlD;
            RD1E        <= RD1D;
            RD2E        <= RD2D;
            PCE         <= PCD;
            PCPlus4E    <= PCPlus4D;
            ExtImmE     <= ExtImmD;
            Rs1E        <= Rs1D;
            Rs2E        <= Rs2D;
            RdE         <= RdD;
        end
    end

`ifdef ID_EX_BUBBLE_CNT_EN
    // A bubble enters Execute on a flush or on a non-stalled invalid load.
    logic        bubble_in;
    logic [15:0] bubble_cnt;

    assign bubble_in = FlushE | (~StallE & ~ValidD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bubble_cnt <= '0;
        end else if (bubble_in && bubble_cnt != 16'hFFFF) begin
            bubble_cnt <= bubble_cnt + 16'd1;
        end
    end

    assign BubbleCntE = bubble_cnt;
`else
    assign BubbleCntE = '0;
`endif

endmodule

// File: doc/id_ex_reg.md
ID_EX_REG -- requirements
Module: id_ex_reg

Interface
REQ-001 Parameter XLEN, default 32, datapath width of RD1/RD2/PC/ExtImm/PCPlus4 fields.
REQ-002 Parameter ALUC_W, default 3, width of ALUControl field.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 FlushE  in  1  load bubble next edge (hazard unit).
REQ-007 StallE  in  1  hold current contents next edge.
REQ-008 ValidD  in  1  Decode-stage instruction valid.
REQ-009 RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD  in  1 each  Decode control bits.
REQ-010 ResultSrcD  in  2  result mux select; ALUControlD  in  ALUC_W  ALU operation.
REQ-011 RD1D, RD2D  in  XLEN  register-file read data.
REQ-012 PCD, PCPlus4D  in  XLEN  Decode PC and PC+4.
REQ-013 ExtImmD  in  XLEN  sign-extended immediate from the Extend block.
REQ-014 Rs1D, Rs2D, RdD  in  5 each  register indices.
REQ-015 Matching *E outputs (ValidE, RegWriteE ... RdE) with identical widths.
REQ-016 BubbleCntE  out  16  bubble counter (see Configuration).

Function
REQ-017 Priority per rising edge: FlushE > StallE > load.
REQ-018 Load: every *E output takes its *D input value; latency exactly 1 cycle.
REQ-019 Flush: all *E outputs become 0 (ValidE=0, RegWriteE=0, MemWriteE=0, JumpE=0, BranchE=0, data fields 0), regardless of StallE.
REQ-020 Stall (FlushE=0): all *E outputs hold previous values, D inputs ignored.
REQ-021 ExtImmD captured at exactly XLEN bits; no truncation or re-extension.
REQ-022 ValidD=0 on load: control bits RegWriteE, MemWriteE, JumpE, BranchE forced 0; data fields still captured; ValidE=0.
REQ-023 No combinational path from any input to any output.
REQ-024 Back-to-back flushes keep outputs at 0; first non-flush, non-stall edge loads normally.

Reset
REQ-025 reset_n low asynchronously forces all *E outputs and BubbleCntE to 0 without waiting for clk.
REQ-026 Reset asserted mid-stall or mid-flush overrides both; after release, first rising edge follows REQ-017.
REQ-027 Reset release is synchronous to clk by the surrounding system; block needs no internal synchronizer.

Configuration
REQ-028 Macro ID_EX_BUBBLE_CNT_EN selects the bubble counter.
REQ-029 Defined: BubbleCntE increments by 1 on each edge where a bubble is written (FlushE=1, or load with ValidD=0); holds on stall or valid load; saturates at 0xFFFF.
REQ-030 Undefined: BubbleCntE tied to 0, no counter flops synthesized; all other behaviour identical.

Verification
REQ-031 Load: reset, then ValidD=1, RegWriteD=1, ExtImmD=0xFFFFF800, RdD=5, PCD=0x100 -> next edge ValidE=1, RegWriteE=1, ExtImmE=0xFFFFF800, RdE=5, PCE=0x100.
REQ-032 Stall: load PCD=0x200, then StallE=1 for 3 edges with PCD=0x204,0x208,0x20C -> PCE stays 0x200 all 3 cycles, loads 0x20C when StallE drops.
REQ-033 Flush+stall: contents PCE=0x300, RegWriteE=1; FlushE=1 and StallE=1 same edge -> all outputs 0; counter (if enabled) 0->1.
REQ-034 Invalid load: ValidD=0, MemWriteD=1, RD2D=0xDEADBEEF -> MemWriteE=0, ValidE=0, RD2E=0xDEADBEEF.
REQ-035 Async reset: outputs loaded, reset_n low between edges -> all outputs 0 before next clk edge, BubbleCntE=0.
REQ-036 Saturation (ID_EX_BUBBLE_CNT_EN defined): FlushE=1 for 65540 edges -> BubbleCntE=0xFFFF; without macro BubbleCntE=0 throughout.
